// File: rtl/rx_frame_shift_reg_pkg.sv
// Shared RX engine constants: frame defaults and start/stop bit levels.
package rx_frame_shift_reg_pkg;

    localparam int   DEF_WIDTH = 10;
    localparam int   DEF_CNT_W = 6;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/rx_frame_shift_reg_bit_counter.sv
// Modulo-WIDTH received-bit counter with a combinational wrap strobe.
module rx_bit_counter
    import rx_frame_shift_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    output logic [CNT_W-1:0] BIT_CNT,
    output logic             WRAP
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign WRAP    = EN && (cnt_q == CNT_W'(WIDTH - 1));
    assign BIT_CNT = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (WRAP) begin
            cnt_d = '0;
        end else if (EN) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_frame_shift_reg.sv
// Serial-to-parallel RX shift register with frame latch, DONE pulse
// and optional start/stop framing check.
module rx_frame_shift_reg
    import rx_frame_shift_reg_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter bit LSB_FIRST   = 1'b1,
    parameter bit CHECK_FRAME = 1'b1,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SH,
    input  logic             SDI,
    input  logic             CLR,
    output logic [WIDTH-1:0] SH_DATA,
    output logic [WIDTH-1:0] DATA,
    output logic             DONE,
    output logic             FERR,
    output logic [CNT_W-1:0] BIT_CNT
);

    // Bit positions of the first and last received bits in a frame.
    localparam int FIRST = LSB_FIRST ? 0 : WIDTH - 1;
    localparam int LAST  = LSB_FIRST ? WIDTH - 1 : 0;

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] data_q;
    logic             done_q;
    logic             ferr_q;
    logic             ferr_d;
    logic             en;
    logic             wrap;

    assign en = SH & ~CLR;

    rx_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (en),
        .CLR     (CLR),
        .BIT_CNT (BIT_CNT),
        .WRAP    (wrap)
    );

    always_comb begin
        sh_d = sh_q;
        if (CLR) begin
            sh_d = '0;
        end else if (SH) begin
            if (LSB_FIRST) begin
                sh_d = {SDI, sh_q[WIDTH-1:1]};
            end else begin
                sh_d = {sh_q[WIDTH-2:0], SDI};
            end
        end
    end

    always_comb begin
        ferr_d = 1'b0;
        if (CHECK_FRAME) begin
            ferr_d = (sh_d[FIRST] != START_BIT) || (sh_d[LAST] != STOP_BIT);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sh_q   <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            done_q <= wrap;
            if (wrap) begin
                data_q <= sh_d;
                ferr_q <= ferr_d;
            end
        end
    end

    assign SH_DATA = sh_q;
    assign DATA    = data_q;
    assign DONE    = done_q;
    assign FERR    = ferr_q;

endmodule

// File: tb/tb_rx_frame_shift_reg.sv
// Directed bench: UART-order 10-bit instance plus an 8-bit MSB-first one.
module tb_rx_frame_shift_reg;

    logic       clk = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_done;

    logic       rst_a, sh_a, sdi_a, clr_a;
    logic [9:0] shd_a, data_a;
    logic       done_a, ferr_a;
    logic [5:0] cnt_a;

    logic       rst_b, sh_b, sdi_b, clr_b;
    logic [7:0] shd_b, data_b;
    logic       done_b, ferr_b;
    logic [5:0] cnt_b;

    always #5 clk = ~clk;

    rx_frame_shift_reg #(
        .WIDTH(10), .LSB_FIRST(1'b1), .CHECK_FRAME(1'b1), .CNT_W(6)
    ) dut_a (
        .CLK(clk), .RST(rst_a), .SH(sh_a), .SDI(sdi_a), .CLR(clr_a),
        .SH_DATA(shd_a), .DATA(data_a), .DONE(done_a), .FERR(ferr_a),
        .BIT_CNT(cnt_a)
    );

    rx_frame_shift_reg #(
        .WIDTH(8), .LSB_FIRST(1'b0), .CHECK_FRAME(1'b0), .CNT_W(6)
    ) dut_b (
        .CLK(clk), .RST(rst_b), .SH(sh_b), .SDI(sdi_b), .CLR(clr_b),
        .SH_DATA(shd_b), .DATA(data_b), .DONE(done_b), .FERR(ferr_b),
        .BIT_CNT(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // LSB-first frame on instance A; frame bit i is sent i-th.
    task automatic send_a(input logic [9:0] f, input int gap, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sh_a  = 1'b1;
            sdi_a = f[i];
            tick();
            if (done_a) n_done++;
            check("a_cnt", 32'(cnt_a), 32'((i + 1) % 10));
            if (i < 9) check("a_nodone", 32'(done_a), 0);
            for (int g = 0; g < gap && i < nbits - 1; g++) begin
                sh_a = 1'b0;
                tick();
                if (done_a) n_done++;
                check("a_gapcnt", 32'(cnt_a), 32'(i + 1));
            end
        end
    endtask

    initial begin
        rst_a = 1'b0; sh_a = 1'b1; sdi_a = 1'b1; clr_a = 1'b1;
        rst_b = 1'b0; sh_b = 1'b0; sdi_b = 1'b0; clr_b = 1'b0;
        tick();
        check("rst_shd", 32'(shd_a), 0);
        check("rst_data", 32'(data_a), 0);
        check("rst_cnt", 32'(cnt_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_ferr", 32'(ferr_a), 0);
        rst_a = 1'b1; clr_a = 1'b0; sh_a = 1'b0;
        rst_b = 1'b1;

        // Test 1
        n_done = 0;
        send_a(10'h2B4, 0, 10);
        check("t1_done", 32'(done_a), 1);
        check("t1_data", 32'(data_a), 32'h2B4);
        check("t1_ferr", 32'(ferr_a), 0);
        check("t1_cnt", 32'(cnt_a), 0);
        sh_a = 1'b0;
        tick();
        check("t1_done_end", 32'(done_a), 0);
        check("t1_ndone", 32'(n_done), 1);

        // Test 2: stop bit low
        n_done = 0;
        send_a(10'h0B4, 0, 10);
        check("t2_done", 32'(done_a), 1);
        check("t2_data", 32'(data_a), 32'h0B4);
        check("t2_ferr", 32'(ferr_a), 1);
        sh_a = 1'b0;
        tick();
        check("t2_hold", 32'(data_a), 32'h0B4);

        // Test 3: three idle cycles between bits
        n_done = 0;
        send_a(10'h2B4, 3, 10);
        check("t3_done", 32'(done_a), 1);
        check("t3_data", 32'(data_a), 32'h2B4);
        check("t3_ferr", 32'(ferr_a), 0);
        sh_a = 1'b0;
        tick();
        check("t3_ndone", 32'(n_done), 1);

        // Test 4: abort with CLR while SH is high
        n_done = 0;
        send_a(10'h0BF, 0, 4);
        clr_a = 1'b1; sh_a = 1'b1; sdi_a = 1'b1;
        tick();
        check("t4_clr_cnt", 32'(cnt_a), 0);
        check("t4_clr_shd", 32'(shd_a), 0);
        check("t4_clr_done", 32'(done_a), 0);
        check("t4_clr_data", 32'(data_a), 32'h2B4);
        clr_a = 1'b0;
        send_a(10'h0B4, 0, 10);
        check("t4_data", 32'(data_a), 32'h0B4);
        check("t4_ferr", 32'(ferr_a), 1);
        check("t4_ndone", 32'(n_done), 1);

        // Test 5: reset mid-frame
        sh_a = 1'b0;
        tick();
        send_a(10'h3FF, 0, 6);
        rst_a = 1'b0; sh_a = 1'b1; sdi_a = 1'b1;
        tick();
        check("t5_shd", 32'(shd_a), 0);
        check("t5_cnt", 32'(cnt_a), 0);
        check("t5_data", 32'(data_a), 0);
        check("t5_ferr", 32'(ferr_a), 0);
        rst_a = 1'b1;
        n_done = 0;
        send_a(10'h2B4, 0, 10);
        check("t5_data2", 32'(data_a), 32'h2B4);
        check("t5_ferr2", 32'(ferr_a), 0);
        check("t5_ndone", 32'(n_done), 1);
        sh_a = 1'b0;

        // Test 6: 8-bit MSB-first, two frames back-to-back, no check
        begin
            logic [7:0] f;
            int         first_done;
            int         nd;
            f = 8'hA5;
            first_done = -1;
            nd = 0;
            for (int k = 0; k < 16; k++) begin
                sh_b  = 1'b1;
                sdi_b = f[7 - (k % 8)];
                tick();
                if (done_b) begin
                    nd++;
                    check("t6_data", 32'(data_b), 32'hA5);
                    check("t6_shd", 32'(shd_b), 32'hA5);
                    check("t6_ferr", 32'(ferr_b), 0);
                    if (first_done < 0) first_done = k;
                    else check("t6_gap", 32'(k - first_done), 8);
                end
            end
            sh_b = 1'b0;
            check("t6_first", 32'(first_done), 7);
            check("t6_ndone", 32'(nd), 2);
            tick();
            check("t6_idle", 32'(done_b), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
